// File: rtl/muldiv_sched_if.sv
// Handshake bundle between the EX stage and the HI/LO sequencer.
// master = EX-stage side (drives requests), slave = muldiv_sched.
interface muldiv_sched_if;
    logic       req_valid;
    logic [2:0] req_op;
    logic       flush;
    logic       xalu_start;
    logic [2:0] xalu_op;
    logic [1:0] hilo_we;
    logic       hilo_sel;
    logic       stall;
    logic       busy;
    logic       done;
    logic       xalu_abort;

    modport master (
        output req_valid, req_op, flush,
        input  xalu_start, xalu_op, hilo_we, hilo_sel,
        input  stall, busy, done, xalu_abort
    );

    modport slave (
        input  req_valid, req_op, flush,
        output xalu_start, xalu_op, hilo_we, hilo_sel,
        output stall, busy, done, xalu_abort
    );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO unit sequencer: launches mult/div, times them, raises stall.
// Ports: clk, reset (async active-low), bus (muldiv_sched_if.slave).
// Option: MULDIV_ABORT_EN lets flush in RUN abort the operation.
module muldiv_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_sched_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                     : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC) > 4) ? $clog2(MAXC) : 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Low during reset and the first cycle after release; masks outputs.
    logic          rdy_q, rdy_d;

    logic       xalu_start;
    logic [2:0] xalu_op;
    logic [1:0] hilo_we;
    logic       hilo_sel;
    logic       stall;
    logic       done;
    logic       xalu_abort;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdy_d      = 1'b1;
        xalu_start = 1'b0;
        xalu_op    = 3'd0;
        hilo_we    = 2'b00;
        hilo_sel   = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        xalu_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rdy_q && bus.req_valid) begin
                    unique case (1'b1)
                        // mfhi/mflo: read select only, flush-agnostic
                        (bus.req_op[2:1] == 2'b11): begin
                            hilo_sel = ~bus.req_op[0];
                        end
                        bus.flush: begin
                        end
                        !bus.req_op[2]: begin
                            xalu_start = 1'b1;
                            xalu_op    = bus.req_op;
                            state_d    = RUN;
                            cnt_d      = bus.req_op[1]
                                       ? CW'(DIV_CYCLES - 1)
                                       : CW'(MULT_CYCLES - 1);
                        end
                        default: begin
                            hilo_we = bus.req_op[0] ? 2'b01 : 2'b10;
                        end
                    endcase
                end
            end
            RUN: begin
                stall = bus.req_valid;
`ifdef MULDIV_ABORT_EN
                if (bus.flush) begin
                    xalu_abort = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`else
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.xalu_start = xalu_start;
    assign bus.xalu_op    = xalu_op;
    assign bus.hilo_we    = hilo_we;
    assign bus.hilo_sel   = hilo_sel;
    assign bus.stall      = stall;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done;
    assign bus.xalu_abort = xalu_abort;
endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched.
// Expected done cycles are queued at launch and popped on done.
module tb_muldiv_sched;
    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   sb[$];

    muldiv_sched_if bus ();

    muldiv_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic fl);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.flush     = fl;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 3'd0, 1'b0);
        step();
        step();
        #1;
        n_checks++;
        if (bus.xalu_start !== 1'b0 || bus.busy !== 1'b0 ||
            bus.stall !== 1'b0 || bus.done !== 1'b0 ||
            bus.hilo_we !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_low start=%b busy=%b stall=%b done=%b we=%b exp all 0",
                     bus.xalu_start, bus.busy, bus.stall, bus.done, bus.hilo_we);
        end
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.xalu_start !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release start=%b busy=%b exp 0 0",
                     bus.xalu_start, bus.busy);
        end
        step();
        drive(1'b0, 3'd0, 1'b0);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_launch busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_mult();
        step();
        drive(1'b1, 3'd0, 1'b0);
        #1;
        n_checks++;
        if (bus.xalu_start !== 1'b1 || bus.xalu_op !== 3'd0) begin
            n_fail++;
            $display("FAIL mult_start start=%b op=%0d exp 1 0",
                     bus.xalu_start, bus.xalu_op);
        end
        sb.push_back(cyc + 5);
        for (int k = 1; k <= 6; k++) begin
            step();
            drive(1'b0, 3'd0, 1'b0);
            #1;
            n_checks++;
            if (bus.busy !== (k <= 5) || bus.done !== (k == 5)) begin
                n_fail++;
                $display("FAIL mult_timing k=%0d busy=%b done=%b exp %b %b",
                         k, bus.busy, bus.done, k <= 5, k == 5);
            end
            if (bus.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL mult_sb done=1 with empty queue");
                end else begin
                    int e = sb.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL mult_sb cycle=%0d exp %0d", cyc, e);
                    end
                end
            end
        end
    endtask

    task automatic test_divu_mflo();
        step();
        drive(1'b1, 3'd3, 1'b0);
        #1;
        n_checks++;
        if (bus.xalu_start !== 1'b1 || bus.xalu_op !== 3'd3) begin
            n_fail++;
            $display("FAIL divu_start start=%b op=%0d exp 1 3",
                     bus.xalu_start, bus.xalu_op);
        end
        sb.push_back(cyc + 10);
        for (int k = 1; k <= 11; k++) begin
            step();
            drive(1'b1, 3'd7, 1'b0);
            #1;
            n_checks++;
            if (bus.stall !== (k <= 10) || bus.xalu_start !== 1'b0 ||
                bus.hilo_we !== 2'b00 || bus.hilo_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL divu_mflo k=%0d stall=%b start=%b we=%b sel=%b exp %b 0 00 0",
                         k, bus.stall, bus.xalu_start, bus.hilo_we,
                         bus.hilo_sel, k <= 10);
            end
            if (bus.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL divu_sb done=1 with empty queue");
                end else begin
                    int e = sb.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL divu_sb cycle=%0d exp %0d", cyc, e);
                    end
                end
            end
        end
        step();
        drive(1'b1, 3'd6, 1'b0);
        #1;
        n_checks++;
        if (bus.hilo_sel !== 1'b1 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mfhi_sel sel=%b stall=%b exp 1 0",
                     bus.hilo_sel, bus.stall);
        end
    endtask

    task automatic test_mthi();
        step();
        drive(1'b1, 3'd4, 1'b1);
        #1;
        n_checks++;
        if (bus.hilo_we !== 2'b00) begin
            n_fail++;
            $display("FAIL mthi_flush we=%b exp 00", bus.hilo_we);
        end
        step();
        drive(1'b1, 3'd4, 1'b0);
        #1;
        n_checks++;
        if (bus.hilo_we !== 2'b10 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_we we=%b busy=%b exp 10 0",
                     bus.hilo_we, bus.busy);
        end
        step();
        drive(1'b1, 3'd5, 1'b0);
        #1;
        n_checks++;
        if (bus.hilo_we !== 2'b01 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo_we we=%b busy=%b exp 01 0",
                     bus.hilo_we, bus.busy);
        end
        step();
        drive(1'b0, 3'd0, 1'b0);
        #1;
        n_checks++;
        if (bus.hilo_we !== 2'b00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mt_idle we=%b busy=%b exp 00 0",
                     bus.hilo_we, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        step();
        drive(1'b1, 3'd0, 1'b0);
        #1;
        sb.push_back(cyc + 5);
        for (int k = 1; k <= 6; k++) begin
            step();
            drive(1'b1, 3'd1, 1'b0);
            #1;
            n_checks++;
            if (bus.xalu_start !== (k == 6)) begin
                n_fail++;
                $display("FAIL b2b_start k=%0d start=%b exp %b",
                         k, bus.xalu_start, k == 6);
            end
            if (bus.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_sb done=1 with empty queue");
                end else begin
                    int e = sb.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL b2b_sb cycle=%0d exp %0d", cyc, e);
                    end
                end
            end
        end
        if (bus.xalu_start === 1'b1) sb.push_back(cyc + 5);
        for (int k = 1; k <= 6; k++) begin
            step();
            drive(1'b0, 3'd0, 1'b0);
            #1;
            if (bus.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_sb2 done=1 with empty queue");
                end else begin
                    int e = sb.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL b2b_sb2 cycle=%0d exp %0d", cyc, e);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain pending=%0d busy=%b exp 0 0",
                     sb.size(), bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        step();
        drive(1'b1, 3'd2, 1'b0);
        #1;
        for (int k = 1; k <= 3; k++) begin
            step();
            drive(1'b1, 3'd0, 1'b0);
            if (k == 3) reset = 1'b0;
            #1;
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b stall=%b exp 0 0",
                     bus.busy, bus.stall);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 2) reset = 1'b1;
            drive(1'b0, 3'd0, 1'b0);
            #1;
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_done k=%0d done=%b exp 0", k, bus.done);
            end
        end
        step();
        drive(1'b1, 3'd2, 1'b0);
        #1;
        n_checks++;
        if (bus.xalu_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_relaunch start=%b exp 1", bus.xalu_start);
        end
        sb.push_back(cyc + 10);
        for (int k = 1; k <= 12; k++) begin
            step();
            drive(1'b0, 3'd0, 1'b0);
            #1;
            if (bus.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_sb done=1 with empty queue");
                end else begin
                    int e = sb.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL rst_sb cycle=%0d exp %0d", cyc, e);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rst_sb_timeout pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_flush_run();
        step();
        drive(1'b1, 3'd0, 1'b0);
        #1;
`ifndef MULDIV_ABORT_EN
        sb.push_back(cyc + 5);
`endif
        for (int k = 1; k <= 7; k++) begin
            step();
            drive(1'b0, 3'd0, k == 2);
            #1;
            if (k == 2) begin
                n_checks++;
`ifdef MULDIV_ABORT_EN
                if (bus.xalu_abort !== 1'b1 || bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_pulse abort=%b done=%b exp 1 0",
                             bus.xalu_abort, bus.done);
                end
`else
                if (bus.xalu_abort !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flush_ignored abort=%b busy=%b exp 0 1",
                             bus.xalu_abort, bus.busy);
                end
`endif
            end
`ifdef MULDIV_ABORT_EN
            if (k == 3) begin
                n_checks++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_idle busy=%b exp 0", bus.busy);
                end
            end
`endif
            if (bus.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL flush_sb done=1 with empty queue");
                end else begin
                    int e = sb.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL flush_sb cycle=%0d exp %0d", cyc, e);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL flush_sb_timeout pending=%0d exp 0", sb.size());
        end
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b0, 3'd0, 1'b0);
        test_reset();
        test_mult();
        test_divu_mflo();
        test_mthi();
        test_back_to_back();
        test_reset_mid_run();
        test_flush_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
